// File: rtl/alu_exec_unit_if.sv
// Handshake and operand/result bus of the ALU execution unit.
// The issuing side uses master; the unit itself uses slave.
interface alu_exec_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [6:0]      op_code;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [1:0]      alu_op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [4:0]      alu_ctrl;
  logic            illegal;

  modport master (
    output in_valid, flush, op_code, funct3, funct7, alu_op, src_a, src_b,
    input  in_ready, out_valid, result, zero, alu_ctrl, illegal
  );
  modport slave (
    input  in_valid, flush, op_code, funct3, funct7, alu_op, src_a, src_b,
    output in_ready, out_valid, result, zero, alu_ctrl, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// RV-style ALU: single-cycle integer ops plus iterative shift-add multiply
// and restoring divide, one bit per cycle, signs applied on the last step.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic            clk,
  input logic            rst,
  alu_exec_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  localparam logic [4:0] C_ADD = 5'd0, C_SUB = 5'd1, C_SLL = 5'd2, C_SLT = 5'd3,
                         C_SLTU = 5'd4, C_XOR = 5'd5, C_SRL = 5'd6, C_SRA = 5'd7,
                         C_OR = 5'd8, C_AND = 5'd9, C_MUL = 5'd16;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   acc_hi, hi_n;
  logic [XLEN-1:0] acc_lo, lo_n, opnd;
  logic            neg_q, neg_r, b_zero;
  logic            out_valid_q, zero_q, ill_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      ctrl_q;

  logic            accept, dec_ill, sgn_a, sgn_b, sa, sb;
  logic [4:0]      dec_ctrl;
  logic [XLEN-1:0] alu_res, mag_a, mag_b, fin;
  logic [SHW-1:0]  shamt;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic            unused_ok;

  assign unused_ok     = &{1'b0, bus.op_code};
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.illegal   = ill_q;
  assign accept        = bus.in_valid && bus.in_ready && !bus.flush;
  assign shamt         = bus.src_b[SHW-1:0];

  always_comb begin
    dec_ctrl = C_ADD;
    dec_ill  = 1'b0;
    case (bus.alu_op)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_SUB;
      2'b11: dec_ill  = 1'b1;
      default: begin
        if (bus.funct7 == 7'b0000001) begin
          if (bus.op_code[5] && ENABLE_M) dec_ctrl = {2'b10, bus.funct3};
          else                            dec_ill  = 1'b1;
        end else begin
          case (bus.funct3)
            3'b000:  dec_ctrl = (bus.op_code[5] && bus.funct7[5]) ? C_SUB : C_ADD;
            3'b001:  dec_ctrl = C_SLL;
            3'b010:  dec_ctrl = C_SLT;
            3'b011:  dec_ctrl = C_SLTU;
            3'b100:  dec_ctrl = C_XOR;
            3'b101:  dec_ctrl = bus.funct7[5] ? C_SRA : C_SRL;
            3'b110:  dec_ctrl = C_OR;
            default: dec_ctrl = C_AND;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      C_ADD:   alu_res = bus.src_a + bus.src_b;
      C_SUB:   alu_res = bus.src_a - bus.src_b;
      C_SLL:   alu_res = bus.src_a << shamt;
      C_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
      C_SLTU:  alu_res = {{(XLEN-1){1'b0}}, bus.src_a < bus.src_b};
      C_XOR:   alu_res = bus.src_a ^ bus.src_b;
      C_SRL:   alu_res = bus.src_a >> shamt;
      C_SRA:   alu_res = $signed(bus.src_a) >>> shamt;
      C_OR:    alu_res = bus.src_a | bus.src_b;
      C_AND:   alu_res = bus.src_a & bus.src_b;
      default: alu_res = '0;
    endcase
    if (dec_ill) alu_res = '0;
  end

  // Operand signedness: divide group keys on funct3[0], multiply group on funct3[1:0].
  assign sgn_a = dec_ctrl[2] ? !bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign sgn_b = dec_ctrl[2] ? !bus.funct3[0] : !bus.funct3[1];
  assign sa    = sgn_a & bus.src_a[XLEN-1];
  assign sb    = sgn_b & bus.src_b[XLEN-1];
  assign mag_a = sa ? -bus.src_a : bus.src_a;
  assign mag_b = sb ? -bus.src_b : bus.src_b;

  always_comb begin
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (state == S_MUL) begin
      hi_n = {1'b0, mul_sum[XLEN:1]};
      lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
    end else begin
      hi_n = div_diff[XLEN] ? div_shift : div_diff;
      lo_n = {acc_lo[XLEN-2:0], !div_diff[XLEN]};
    end
    prod   = {hi_n[XLEN-1:0], lo_n};
    prod_s = neg_q ? -prod : prod;
    // A zero divisor already yields |a| as remainder; only the quotient needs forcing.
    if (!ctrl_q[2])      fin = (ctrl_q == C_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else if (ctrl_q[1])  fin = neg_r ? -hi_n[XLEN-1:0] : hi_n[XLEN-1:0];
    else if (b_zero)     fin = '1;
    else                 fin = neg_q ? -lo_n : lo_n;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept && !dec_ill && dec_ctrl[4]) state_d = dec_ctrl[2] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (cnt == CW'(1)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; acc_hi <= '0; acc_lo <= '0; opnd <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; b_zero <= 1'b0;
      out_valid_q <= 1'b0; result_q <= '0; zero_q <= 1'b0; ctrl_q <= '0; ill_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          ctrl_q <= dec_ill ? C_ADD : dec_ctrl;
          if (dec_ill || !dec_ctrl[4]) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            zero_q      <= (alu_res == '0);
            ill_q       <= dec_ill;
          end else begin
            cnt    <= CW'(XLEN);
            acc_hi <= '0;
            acc_lo <= dec_ctrl[2] ? mag_a : mag_b;
            opnd   <= dec_ctrl[2] ? mag_b : mag_a;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            b_zero <= (bus.src_b == '0);
          end
        end
        S_MUL, S_DIV: begin
          acc_hi <= hi_n;
          acc_lo <= lo_n;
          cnt    <= cnt - CW'(1);
          // Final step publishes the sign-corrected result as DONE is entered.
          if (cnt == CW'(1) && !bus.flush) begin
            out_valid_q <= 1'b1;
            result_q    <= fin;
            zero_q      <= (fin == '0);
            ill_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit at XLEN=32 with the M group enabled.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(32)) bus();
  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {logic [31:0] res; logic z; logic [4:0] ctrl; logic ill;} exp_t;
  typedef struct {logic [1:0] aop; logic [6:0] opc; logic [2:0] f3; logic [6:0] f7;
                  logic [31:0] a; logic [31:0] b;} op_t;

  localparam logic [6:0] R = 7'h33, I = 7'h13, F7S = 7'h20, F7M = 7'h01;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  function automatic op_t mk(input logic [1:0] aop, input logic [6:0] opc, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.aop = aop; o.opc = opc; o.f3 = f3; o.f7 = f7; o.a = a; o.b = b;
    return o;
  endfunction

  function automatic exp_t ex(input logic [31:0] res, input logic [4:0] ctrl, input logic ill);
    exp_t e;
    e.res = res; e.z = (res == 32'd0); e.ctrl = ctrl; e.ill = ill;
    return e;
  endfunction

  task automatic apply(input op_t o);
    bus.alu_op = o.aop; bus.op_code = o.opc; bus.funct3 = o.f3;
    bus.funct7 = o.f7; bus.src_a = o.a; bus.src_b = o.b;
  endtask

  task automatic send(input op_t o);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin @(negedge clk); guard++; end
    apply(o);
    bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int low);
    lat = 1; low = 0;
    while (!bus.out_valid && lat < 200) begin
      if (!bus.in_ready) low++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    apply(mk(2'b00, R, 3'd0, 7'd0, 32'd1, 32'd1));
    bus.in_valid = 1'b1; bus.flush = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.zero !== 1'b0 ||
        bus.alu_ctrl !== 5'd0 || bus.illegal !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL reset: got v=%b res=%h z=%b ctrl=%0d ill=%b rdy=%b, want 0 0 0 0 0 rdy=1",
               bus.out_valid, bus.result, bus.zero, bus.alu_ctrl, bus.illegal, bus.in_ready);
    else passed++;
    bus.in_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_alu();
    op_t o[13]; exp_t x[13]; exp_t e; int lat, low;
    o[0]  = mk(2'b10, R, 3'd0, F7S, 32'd5, 32'd7);                 x[0]  = ex(32'hFFFFFFFE, 5'd1, 0);
    o[1]  = mk(2'b10, R, 3'd5, F7S, 32'h80000000, 32'd4);          x[1]  = ex(32'hF8000000, 5'd7, 0);
    o[2]  = mk(2'b10, R, 3'd5, 7'd0, 32'h80000000, 32'd4);         x[2]  = ex(32'h08000000, 5'd6, 0);
    o[3]  = mk(2'b00, R, 3'd0, 7'd0, 32'hFFFFFFFF, 32'd1);         x[3]  = ex(32'h00000000, 5'd0, 0);
    o[4]  = mk(2'b01, R, 3'd0, 7'd0, 32'd3, 32'd5);                x[4]  = ex(32'hFFFFFFFE, 5'd1, 0);
    o[5]  = mk(2'b10, I, 3'd0, F7S, 32'd5, 32'd7);                 x[5]  = ex(32'd12, 5'd0, 0);
    o[6]  = mk(2'b10, R, 3'd1, 7'd0, 32'd1, 32'd33);               x[6]  = ex(32'd2, 5'd2, 0);
    o[7]  = mk(2'b10, R, 3'd2, 7'd0, 32'hFFFFFFFF, 32'd1);         x[7]  = ex(32'd1, 5'd3, 0);
    o[8]  = mk(2'b10, R, 3'd3, 7'd0, 32'hFFFFFFFF, 32'd1);         x[8]  = ex(32'd0, 5'd4, 0);
    o[9]  = mk(2'b10, R, 3'd4, 7'd0, 32'hF0F0F0F0, 32'hFF00FF00);  x[9]  = ex(32'h0FF00FF0, 5'd5, 0);
    o[10] = mk(2'b10, R, 3'd6, 7'd0, 32'hF0F0F0F0, 32'h0F000000);  x[10] = ex(32'hFFF0F0F0, 5'd8, 0);
    o[11] = mk(2'b10, R, 3'd7, 7'd0, 32'hF0F0F0F0, 32'hFF00FF00);  x[11] = ex(32'hF000F000, 5'd9, 0);
    o[12] = mk(2'b10, R, 3'd5, 7'd0, 32'h80000000, 32'd36);        x[12] = ex(32'h08000000, 5'd6, 0);
    for (int i = 0; i < 13; i++) begin
      sb.push_back(x[i]);
      send(o[i]);
      wait_out(lat, low);
      e = sb.pop_front();
      checks++;
      if (bus.result !== e.res || bus.zero !== e.z || bus.alu_ctrl !== e.ctrl ||
          bus.illegal !== 1'b0 || lat != 1)
        $display("FAIL alu[%0d]: got res=%h z=%b ctrl=%0d ill=%b lat=%0d, want res=%h z=%b ctrl=%0d ill=0 lat=1",
                 i, bus.result, bus.zero, bus.alu_ctrl, bus.illegal, lat, e.res, e.z, e.ctrl);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    op_t o[2]; exp_t e; int lat, low;
    o[0] = mk(2'b11, R, 3'd0, 7'd0, 32'd5, 32'd7);
    o[1] = mk(2'b10, I, 3'd0, F7M, 32'd5, 32'd7);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ex(32'd0, 5'd0, 1'b1));
      send(o[i]);
      wait_out(lat, low);
      e = sb.pop_front();
      checks++;
      if (bus.result !== e.res || bus.zero !== e.z || bus.illegal !== e.ill || lat != 1)
        $display("FAIL illegal[%0d]: got res=%h z=%b ill=%b lat=%0d, want res=0 z=1 ill=1 lat=1",
                 i, bus.result, bus.zero, bus.illegal, lat);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    op_t o[3]; exp_t x[3]; exp_t e;
    o[0] = mk(2'b00, R, 3'd0, 7'd0, 32'd1, 32'd2);      x[0] = ex(32'd3, 5'd0, 0);
    o[1] = mk(2'b01, R, 3'd0, 7'd0, 32'd10, 32'd4);     x[1] = ex(32'd6, 5'd1, 0);
    o[2] = mk(2'b10, R, 3'd7, 7'd0, 32'hFF, 32'h0F);    x[2] = ex(32'h0F, 5'd9, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== e.res || bus.alu_ctrl !== e.ctrl)
          $display("FAIL b2b[%0d]: got v=%b res=%h ctrl=%0d, want v=1 res=%h ctrl=%0d",
                   i - 1, bus.out_valid, bus.result, bus.alu_ctrl, e.res, e.ctrl);
        else passed++;
      end
      if (i < 3) begin apply(o[i]); bus.in_valid = 1'b1; sb.push_back(x[i]); end
      else bus.in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0F)
      $display("FAIL hold: got v=%b res=%h, want v=0 res=0000000f", bus.out_valid, bus.result);
    else passed++;
  endtask

  task automatic test_muldiv();
    op_t o[15]; exp_t x[15]; exp_t e; int lat, low;
    o[0]  = mk(2'b10, R, 3'd1, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF); x[0]  = ex(32'h00000000, 5'd17, 0);
    o[1]  = mk(2'b10, R, 3'd3, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF); x[1]  = ex(32'hFFFFFFFE, 5'd19, 0);
    o[2]  = mk(2'b10, R, 3'd0, F7M, 32'hFFFFFFFD, 32'd7);        x[2]  = ex(32'hFFFFFFEB, 5'd16, 0);
    o[3]  = mk(2'b10, R, 3'd2, F7M, 32'hFFFFFFFF, 32'd2);        x[3]  = ex(32'hFFFFFFFF, 5'd18, 0);
    o[4]  = mk(2'b10, R, 3'd3, F7M, 32'h80000000, 32'd2);        x[4]  = ex(32'h00000001, 5'd19, 0);
    o[5]  = mk(2'b10, R, 3'd4, F7M, 32'h80000000, 32'hFFFFFFFF); x[5]  = ex(32'h80000000, 5'd20, 0);
    o[6]  = mk(2'b10, R, 3'd5, F7M, 32'd9, 32'd0);               x[6]  = ex(32'hFFFFFFFF, 5'd21, 0);
    o[7]  = mk(2'b10, R, 3'd7, F7M, 32'd9, 32'd0);               x[7]  = ex(32'd9, 5'd23, 0);
    o[8]  = mk(2'b10, R, 3'd4, F7M, 32'hFFFFFFF9, 32'd2);        x[8]  = ex(32'hFFFFFFFD, 5'd20, 0);
    o[9]  = mk(2'b10, R, 3'd6, F7M, 32'hFFFFFFF9, 32'd2);        x[9]  = ex(32'hFFFFFFFF, 5'd22, 0);
    o[10] = mk(2'b10, R, 3'd6, F7M, 32'h80000000, 32'hFFFFFFFF); x[10] = ex(32'h00000000, 5'd22, 0);
    o[11] = mk(2'b10, R, 3'd4, F7M, 32'hFFFFFFF9, 32'd0);        x[11] = ex(32'hFFFFFFFF, 5'd20, 0);
    o[12] = mk(2'b10, R, 3'd6, F7M, 32'hFFFFFFF9, 32'd0);        x[12] = ex(32'hFFFFFFF9, 5'd22, 0);
    o[13] = mk(2'b10, R, 3'd5, F7M, 32'd100, 32'd7);             x[13] = ex(32'd14, 5'd21, 0);
    o[14] = mk(2'b10, R, 3'd7, F7M, 32'd100, 32'd7);             x[14] = ex(32'd2, 5'd23, 0);
    for (int i = 0; i < 15; i++) begin
      sb.push_back(x[i]);
      send(o[i]);
      wait_out(lat, low);
      e = sb.pop_front();
      checks++;
      if (bus.result !== e.res || bus.zero !== e.z || bus.alu_ctrl !== e.ctrl ||
          bus.illegal !== 1'b0 || lat != 33 || low != 32)
        $display("FAIL muldiv[%0d]: got res=%h z=%b ctrl=%0d ill=%b lat=%0d busy=%0d, want res=%h z=%b ctrl=%0d ill=0 lat=33 busy=32",
                 i, bus.result, bus.zero, bus.alu_ctrl, bus.illegal, lat, low, e.res, e.z, e.ctrl);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== e.res)
        $display("FAIL muldiv_pulse[%0d]: got v=%b rdy=%b res=%h, want v=0 rdy=1 res=%h",
                 i, bus.out_valid, bus.in_ready, bus.result, e.res);
      else passed++;
    end
  endtask

  task automatic test_flush();
    int seen = 0; int lat, low; exp_t e;
    send(mk(2'b10, R, 3'd4, F7M, 32'd1000, 32'd3));
    repeat (9) @(posedge clk);
    @(negedge clk) bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL flush_ready: got rdy=%b v=%b, want rdy=1 v=0", bus.in_ready, bus.out_valid);
    else passed++;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen++; end
    checks++;
    if (seen != 0) $display("FAIL flush_silent: got %0d pulses, want 0", seen);
    else passed++;
    sb.push_back(ex(32'd5, 5'd0, 0));
    send(mk(2'b00, R, 3'd0, 7'd0, 32'd2, 32'd3));
    wait_out(lat, low);
    e = sb.pop_front();
    checks++;
    if (bus.result !== e.res || lat != 1)
      $display("FAIL flush_add: got res=%h lat=%0d, want res=%h lat=1", bus.result, lat, e.res);
    else passed++;
    @(negedge clk);
    apply(mk(2'b10, R, 3'd0, F7M, 32'd3, 32'd3));
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0; bus.flush = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL flush_wins: got rdy=%b v=%b, want rdy=1 v=0", bus.in_ready, bus.out_valid);
    else passed++;
  endtask

  task automatic test_rst_mid();
    int seen = 0;
    send(mk(2'b10, R, 3'd3, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF));
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.zero !== 1'b0 ||
        bus.alu_ctrl !== 5'd0 || bus.illegal !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL rst_mid: got v=%b res=%h z=%b ctrl=%0d ill=%b rdy=%b, want 0 0 0 0 0 rdy=1",
               bus.out_valid, bus.result, bus.zero, bus.alu_ctrl, bus.illegal, bus.in_ready);
    else passed++;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen++; end
    checks++;
    if (seen != 0) $display("FAIL rst_silent: got %0d pulses, want 0", seen);
    else passed++;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    apply(mk(2'b00, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0));
    test_reset();
    test_alu();
    test_illegal();
    test_back_to_back();
    test_muldiv();
    test_flush();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
